// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: sync pulses, visible/border/retrace flags,
// pixel/line counters and the scrolled framebuffer row for the scan doubler.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 11,
  parameter int H_SYNC    = 56,
  parameter int H_BP      = 61,
  parameter int V_BORDER  = 32,
  parameter int V_PICTURE = 512,
  parameter int V_FP      = 21,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 22,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int HCNT_W    = 10,
  parameter int VCNT_W    = 10,
  parameter int FB_ROW_W  = 9
) (
  input  logic                clk24,
  input  logic                reset,
  input  logic                ce,
  input  logic [7:0]          video_scroll_reg,
  output logic                hsync,
  output logic                vsync,
  output logic                video_active,
  output logic                bordery,
  output logic                retrace,
  output logic [FB_ROW_W-1:0] fb_row,
  output logic [HCNT_W-1:0]   hcount,
  output logic [VCNT_W-1:0]   vcount,
  output logic                line_start,
  output logic                frame_start
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_VISIBLE = 2 * V_BORDER + V_PICTURE;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam bit PARAMS_OK = (H_SYNC >= 1) && (V_SYNC >= 1) && (H_ACTIVE >= 1) &&
                             (V_PICTURE >= 1) && (FB_ROW_W >= 8) &&
                             (H_TOTAL <= (1 << HCNT_W)) && (V_TOTAL <= (1 << VCNT_W));

  localparam logic [HCNT_W-1:0] H_LAST       = HCNT_W'(H_TOTAL - 1);
  localparam logic [HCNT_W-1:0] H_ACT_END    = HCNT_W'(H_ACTIVE);
  localparam logic [HCNT_W-1:0] H_SYNC_FIRST = HCNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCNT_W-1:0] H_SYNC_LAST  = HCNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VCNT_W-1:0] V_LAST       = VCNT_W'(V_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_PIC_FIRST  = VCNT_W'(V_BORDER);
  localparam logic [VCNT_W-1:0] V_PIC_END    = VCNT_W'(V_BORDER + V_PICTURE);
  localparam logic [VCNT_W-1:0] V_VIS_END    = VCNT_W'(V_VISIBLE);
  localparam logic [VCNT_W-1:0] V_SYNC_FIRST = VCNT_W'(V_VISIBLE + V_FP);
  localparam logic [VCNT_W-1:0] V_SYNC_LAST  = VCNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

  if (!PARAMS_OK) begin : g_param_check
    $error("video_timing_gen: illegal timing or width parameters");
  end

  logic [HCNT_W-1:0]   r_hcount;
  logic [VCNT_W-1:0]   r_vcount;
  logic [FB_ROW_W-1:0] r_fb_row;
  logic                r_first;
  logic                r_hsync;
  logic                r_vsync;
  logic                r_active;
  logic                r_bordery;
  logic                r_retrace;
  logic                r_line_start;
  logic                r_frame_start;

  logic [HCNT_W-1:0]   w_hnext;
  logic [VCNT_W-1:0]   w_vnext;
  logic [FB_ROW_W-1:0] w_fb_load;
  logic [FB_ROW_W-1:0] w_fb_next;
  logic                w_line;
  logic                w_frame;
  logic                w_hsync_on;
  logic                w_vsync_on;
  logic                w_active;
  logic                w_bordery;
  logic                w_retrace;

  if (FB_ROW_W == 8) begin : g_fb8
    assign w_fb_load = video_scroll_reg;
  end else begin : g_fbn
    assign w_fb_load = {video_scroll_reg, {(FB_ROW_W-8){1'b1}}};
  end

  // Next raster position; the first enabled cycle after reset presents (0,0) itself
  always_comb begin
    w_hnext = r_hcount;
    w_vnext = r_vcount;
    if (r_first) begin
      w_hnext = '0;
      w_vnext = '0;
    end else if (r_hcount == H_LAST) begin
      w_hnext = '0;
      if (r_vcount == V_LAST) begin
        w_vnext = '0;
      end else begin
        w_vnext = r_vcount + VCNT_W'(1);
      end
    end else begin
      w_hnext = r_hcount + HCNT_W'(1);
      w_vnext = r_vcount;
    end
  end

  // Decode of the upcoming position so registered flags line up with the counters
  always_comb begin
    w_line     = (w_hnext == '0);
    w_frame    = (w_hnext == '0) && (w_vnext == '0);
    w_hsync_on = (w_hnext >= H_SYNC_FIRST) && (w_hnext <= H_SYNC_LAST);
    w_vsync_on = (w_vnext >= V_SYNC_FIRST) && (w_vnext <= V_SYNC_LAST);
    w_active   = (w_hnext < H_ACT_END) && (w_vnext < V_VIS_END);
    w_bordery  = (w_vnext < V_PIC_FIRST) || ((w_vnext >= V_PIC_END) && (w_vnext < V_VIS_END));
    w_retrace  = (w_vnext >= V_VIS_END);
    w_fb_next  = r_fb_row;
    if (!w_line) begin
      w_fb_next = r_fb_row;
    end else if (w_vnext == V_PIC_FIRST) begin
      w_fb_next = w_fb_load;
    end else begin
      w_fb_next = r_fb_row - FB_ROW_W'(1);
    end
  end

  // State and output registers; polarity is applied only here
  always_ff @(posedge clk24) begin
    if (reset) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_fb_row      <= '0;
      r_first       <= 1'b1;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_active      <= 1'b0;
      r_bordery     <= 1'b0;
      r_retrace     <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (ce) begin
      r_hcount      <= w_hnext;
      r_vcount      <= w_vnext;
      r_fb_row      <= w_fb_next;
      r_first       <= 1'b0;
      r_hsync       <= w_hsync_on ? HSYNC_POL : ~HSYNC_POL;
      r_vsync       <= w_vsync_on ? VSYNC_POL : ~VSYNC_POL;
      r_active      <= w_active;
      r_bordery     <= w_bordery;
      r_retrace     <= w_retrace;
      r_line_start  <= w_line;
      r_frame_start <= w_frame;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign hcount       = r_hcount;
  assign vcount       = r_vcount;
  assign fb_row       = r_fb_row;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign video_active = r_active;
  assign bordery      = r_bordery;
  assign retrace      = r_retrace;
  assign line_start   = r_line_start;
  assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: a default-timing instance and a tiny-raster instance run side by side.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, ce_a, rst_b, ce_b;
  logic [7:0] scr_a, scr_b;

  logic       a_hs, a_vs, a_act, a_bdy, a_ret, a_ls, a_fs;
  logic [8:0] a_fb;
  logic [9:0] a_h, a_v;
  logic       b_hs, b_vs, b_act, b_bdy, b_ret, b_ls, b_fs;
  logic [9:0] b_fb;
  logic [9:0] b_h, b_v;

  video_timing_gen dut_a (
    .clk24(clk), .reset(rst_a), .ce(ce_a), .video_scroll_reg(scr_a),
    .hsync(a_hs), .vsync(a_vs), .video_active(a_act), .bordery(a_bdy), .retrace(a_ret),
    .fb_row(a_fb), .hcount(a_h), .vcount(a_v), .line_start(a_ls), .frame_start(a_fs)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_BORDER(1), .V_PICTURE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .FB_ROW_W(10)
  ) dut_b (
    .clk24(clk), .reset(rst_b), .ce(ce_b), .video_scroll_reg(scr_b),
    .hsync(b_hs), .vsync(b_vs), .video_active(b_act), .bordery(b_bdy), .retrace(b_ret),
    .fb_row(b_fb), .hcount(b_h), .vcount(b_v), .line_start(b_ls), .frame_start(b_fs)
  );

  wire [36:0] act_a = {a_h, a_v, a_hs, a_vs, a_act, a_bdy, a_ret, a_ls, a_fs, 1'b0, a_fb};
  wire [36:0] act_b = {b_h, b_v, b_hs, b_vs, b_act, b_bdy, b_ret, b_ls, b_fs, b_fb};

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference raster description, index 0 = defaults, 1 = tiny raster
  int p_htot [2] = '{768, 16};
  int p_hact [2] = '{640, 8};
  int p_hss  [2] = '{651, 10};
  int p_hsl  [2] = '{56, 3};
  int p_vb   [2] = '{32, 1};
  int p_vpic [2] = '{512, 4};
  int p_vvis [2] = '{576, 6};
  int p_vtot [2] = '{624, 10};
  int p_vss  [2] = '{597, 7};
  int p_vsl  [2] = '{5, 2};
  int p_hpol [2] = '{0, 1};
  int p_vpol [2] = '{0, 1};
  int p_fbw  [2] = '{9, 10};

  int          m_n  [2];
  int          m_fb [2];
  logic [36:0] m_o  [2];

  function automatic logic [36:0] pack(input int h, input int v, input logic hs, input logic vs,
                                       input logic act, input logic bdy, input logic ret,
                                       input logic ls, input logic fs, input int fb);
    return {10'(h), 10'(v), hs, vs, act, bdy, ret, ls, fs, 10'(fb)};
  endfunction

  // Position is derived from the number of enabled cycles since reset
  task automatic model(input int s, input bit rst, input bit ce, input logic [7:0] scr);
    int h, v, w;
    logic hp, vp, hs, vs, act, bdy, ret, ls, fs;
    hp = (p_hpol[s] != 0);
    vp = (p_vpol[s] != 0);
    w  = p_fbw[s];
    if (rst) begin
      m_n[s]  = -1;
      m_fb[s] = 0;
      m_o[s]  = pack(0, 0, ~hp, ~vp, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end else if (ce) begin
      m_n[s] = m_n[s] + 1;
      h   = m_n[s] % p_htot[s];
      v   = (m_n[s] / p_htot[s]) % p_vtot[s];
      ls  = (h == 0);
      fs  = (h == 0) && (v == 0);
      hs  = (h >= p_hss[s] && h < p_hss[s] + p_hsl[s]) ? hp : ~hp;
      vs  = (v >= p_vss[s] && v < p_vss[s] + p_vsl[s]) ? vp : ~vp;
      act = (h < p_hact[s]) && (v < p_vvis[s]);
      bdy = (v < p_vb[s]) || (v >= p_vb[s] + p_vpic[s] && v < p_vvis[s]);
      ret = (v >= p_vvis[s]);
      if (ls) begin
        if (v == p_vb[s]) m_fb[s] = (int'(scr) << (w - 8)) | ((1 << (w - 8)) - 1);
        else m_fb[s] = (m_fb[s] - 1) & ((1 << w) - 1);
      end
      m_o[s] = pack(h, v, hs, vs, act, bdy, ret, ls, fs, m_fb[s]);
    end else begin
      m_o[s][11:10] = 2'b00;
    end
  endtask

  typedef struct packed {
    logic [36:0] a;
    logic [36:0] b;
  } sb_t;
  sb_t q[$];

  // Monitor: one expected record per clock edge, compared after the edge
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_a", 64'(act_a), 64'(e.a));
        chk("sb_b", 64'(act_b), 64'(e.b));
      end
    end
  end

  // Hand-computed landmarks on the live outputs
  initial begin
    logic p_a_hs, p_b_hs, p_b_vs, p_b_ls;
    int   a_ls_last;
    a_ls_last = -1;
    p_a_hs = 1'b1; p_b_hs = 1'b0; p_b_vs = 1'b0; p_b_ls = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc >= 4) begin
        if (p_a_hs && !a_hs) chk("a_hsync_fall_at", 64'(a_h), 64'd651);
        if (!p_a_hs && a_hs) chk("a_hsync_rise_at", 64'(a_h), 64'd707);
        if (a_ls) begin
          if (a_ls_last >= 0) chk("a_line_period", 64'(cyc - a_ls_last), 64'd768);
          a_ls_last = cyc;
          if (a_v == 10'd32) chk("a_fb_line32", 64'(a_fb), 64'h1FF);
          if (a_v == 10'd33) chk("a_fb_line33", 64'(a_fb), 64'h1FE);
        end
        if (a_h == 10'd639 && a_v < 10'd576) chk("a_active_639", 64'(a_act), 64'd1);
        if (a_h == 10'd640) chk("a_active_640", 64'(a_act), 64'd0);
        if (!p_b_hs && b_hs) chk("b_hsync_rise_at", 64'(b_h), 64'd10);
        if (p_b_hs && !b_hs) chk("b_hsync_fall_at", 64'(b_h), 64'd13);
        if (!p_b_vs && b_vs) chk("b_vsync_rise_at", 64'({b_v, b_h}), 64'({10'd7, 10'd0}));
        if (p_b_vs && !b_vs) chk("b_vsync_fall_at", 64'({b_v, b_h}), 64'({10'd9, 10'd0}));
        if (b_fs) chk("b_frame_start_pos", 64'({b_v, b_h, b_ls}), 64'({10'd0, 10'd0, 1'b1}));
        if (b_ls) chk("b_line_start_width", 64'(p_b_ls), 64'd0);
      end
      if (rst_a) a_ls_last = -1;
      p_a_hs = a_hs; p_b_hs = b_hs; p_b_vs = b_vs; p_b_ls = b_ls;
    end
  end

  // Stimulus: reset both, mid-frame resets, scroll changes, ce 1-of-3 phase
  initial begin
    int  a_left, b_left, b_frames;
    bit  a_done, b_done;
    logic [9:0] bh, bv;
    a_left = 0; b_left = 0; b_frames = 0; a_done = 1'b0; b_done = 1'b0;
    scr_a = 8'hFF;
    scr_b = 8'hFF;
    for (int k = 0; k < 30000; k++) begin
      bh = m_o[1][36:27];
      bv = m_o[1][26:17];
      if (!a_done && k >= 3 && m_o[0][36:27] == 10'd400 && m_o[0][26:17] == 10'd3) begin
        a_left = 3;
        a_done = 1'b1;
      end
      if (!b_done && b_frames == 9 && bv == 10'd6 && bh == 10'd5) begin
        b_left = 3;
        b_done = 1'b1;
      end
      if (bh == 10'd0 && bv == 10'd3 && b_frames == 2) scr_b = 8'h10;
      if (bh == 10'd0 && bv == 10'd3 && b_frames == 4) scr_b = 8'h00;
      rst_a = (k < 3) || (a_left > 0);
      rst_b = (k < 3) || (b_left > 0);
      if (a_left > 0) a_left--;
      if (b_left > 0) b_left--;
      ce_a = 1'b1;
      ce_b = (!b_done && b_frames >= 6 && b_frames <= 8) ? (k % 3 == 0) : 1'b1;
      model(0, rst_a, ce_a, scr_a);
      model(1, rst_b, ce_b, scr_b);
      q.push_back('{a: m_o[0], b: m_o[1]});
      if (m_o[1][10]) b_frames++;
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
